// File: rtl/interp_fir_pp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_fir_pp
// Brief    : Parametrised polyphase FIR interpolator (L outputs per input)
//            with a valid/ready handshake on both sides.
//            Define INTERP_SAT_EN to clamp results instead of wrapping them.
// Revision : 1.0 - initial release
// ============================================================================
module interp_fir_pp #(
  parameter int                     IN_W   = 15,
  parameter int                     OUT_W  = 18,
  parameter int                     TAPS   = 4,
  parameter int                     L      = 2,
  parameter int                     COEF_W = 4,
  parameter logic [TAPS*COEF_W-1:0] COEFS  = 16'h1FF1,
  parameter int                     SHIFT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  xin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out
);

  localparam int c_D     = TAPS / L;
  localparam int c_ACC_W = IN_W + COEF_W + $clog2(c_D);
  localparam int c_EXT_W = ((c_ACC_W > OUT_W) ? c_ACC_W : OUT_W) + 1;
  localparam int c_PW    = $clog2(L);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]               r_state;
  logic [c_PW-1:0]          r_phase;
  logic signed [IN_W-1:0]   r_d [c_D];
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_out_valid;

  logic signed [COEF_W-1:0] w_coef [TAPS];
  logic [c_PW-1:0]          w_sel;
  logic signed [c_ACC_W-1:0] w_acc;
  logic signed [c_ACC_W-1:0] w_sh;
  logic signed [c_EXT_W-1:0] w_ext;
  logic signed [OUT_W-1:0]  w_res;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
    assign w_coef[gi] = $signed(COEFS[gi*COEF_W +: COEF_W]);
  end

  // LOAD computes phase 0; in EMIT the next phase is precomputed so a
  // fire can register it on the same edge.
  always_comb begin
    w_sel = (r_state == S_LOAD) ? '0 : r_phase + c_PW'(1);
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < c_D; k++) begin
      for (int p = 0; p < L; p++) begin
        if (w_sel == c_PW'(p)) begin
          w_acc = w_acc + c_ACC_W'(w_coef[k*L+p]) * c_ACC_W'(r_d[k]);
        end
      end
    end
  end

  always_comb begin
    w_sh  = w_acc >>> SHIFT;
    w_ext = c_EXT_W'(w_sh);
  end

`ifdef INTERP_SAT_EN
  localparam logic signed [c_EXT_W-1:0] c_MAX =
    {{(c_EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_EXT_W-1:0] c_MIN =
    {{(c_EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (w_ext > c_MAX) begin
      w_res = c_MAX[OUT_W-1:0];
    end else if (w_ext < c_MIN) begin
      w_res = c_MIN[OUT_W-1:0];
    end else begin
      w_res = w_ext[OUT_W-1:0];
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_ext[c_EXT_W-1:OUT_W];

  always_comb begin
    w_res = w_ext[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < c_D; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = c_D - 1; k > 0; k--) begin
              r_d[k] <= r_d[k-1];
            end
            r_d[0]  <= xin;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_out       <= w_res;
          r_phase     <= '0;
          r_out_valid <= 1'b1;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_phase == c_PW'(L - 1)) begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_out   <= w_res;
              r_phase <= r_phase + c_PW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_interp_fir_pp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_interp_fir_pp
// Brief    : Self-checking bench for interp_fir_pp against a sum-of-products
//            reference model (default, overflow and L=3 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_fir_pp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic               d_in_valid, d_out_ready;
  logic signed [14:0] xin;
  wire                d_in_ready, d_out_valid;
  wire signed [17:0]  d_out;

  logic               ovf_iv;
  wire                ovf_rdy, ovf_ov;
  wire signed [14:0]  ovf_out;

  logic               l3_iv;
  wire                l3_rdy, l3_ov;
  wire signed [17:0]  l3_out;

  interp_fir_pp u_dut (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .xin(xin), .out_valid(d_out_valid), .out_ready(d_out_ready), .out(d_out)
  );

  interp_fir_pp #(.OUT_W(15), .SHIFT(0)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(ovf_iv), .in_ready(ovf_rdy),
    .xin(xin), .out_valid(ovf_ov), .out_ready(1'b1), .out(ovf_out)
  );

  interp_fir_pp #(.TAPS(6), .L(3), .COEFS(24'h121121), .SHIFT(0)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(l3_iv), .in_ready(l3_rdy),
    .xin(xin), .out_valid(l3_ov), .out_ready(1'b1), .out(l3_out)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y_p = sum_k coef[k*l+p] * x_k, shifted, then clamped or wrapped to ow bits
  function automatic longint ref_y(input int taps, input int l,
                                   input logic [63:0] coefs, input int sh,
                                   input int ow, input longint x0,
                                   input longint x1, input int p);
    longint acc = 0;
    longint c, v, m;
    for (int k = 0; k < taps / l; k++) begin
      c = longint'((coefs >> ((k*l + p) * 4)) & 64'hF);
      if (c > 7) c -= 16;
      acc += c * ((k == 0) ? x0 : x1);
    end
    v = acc >>> sh;
    m = longint'(1) << (ow - 1);
`ifdef INTERP_SAT_EN
    if (v > m - 1) v = m - 1;
    if (v < -m) v = -m;
`else
    v = v & ((m << 1) - 1);
    if (v >= m) v -= (m << 1);
`endif
    return v;
  endfunction

  longint h0 = 0, h1 = 0;
  longint sh0 [2] = '{0, 0};
  longint sh1 [2] = '{0, 0};

  // max_stall < 0: stall exactly -max_stall cycles before phase 0 only
  task automatic run_txn(input longint x, input int max_stall);
    longint y;
    int st;
    h1 = h0;
    h0 = x;
    xin = 15'(x);
    d_in_valid = 1'b1;
    check("idle_rdy", d_in_ready, 1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    check("load_rdy", d_in_ready, 0);
    check("load_ov", d_out_valid, 0);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      y = ref_y(4, 2, 64'h1FF1, 1, 18, h0, h1, p);
      if (max_stall < 0) st = (p == 0) ? -max_stall : 0;
      else if (max_stall == 0) st = 0;
      else st = $urandom_range(max_stall);
      for (int s = 0; s < st; s++) begin
        d_out_ready = 1'b0;
        d_in_valid  = 1'($urandom_range(1));
        xin         = 15'($urandom);
        check("stall_ov", d_out_valid, 1);
        check("stall_out", d_out, y);
        @(posedge clk); #1;
      end
      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      check("out_valid", d_out_valid, 1);
      check("out", d_out, y);
      check("emit_rdy", d_in_ready, 0);
      @(posedge clk); #1;
    end
    d_out_ready = 1'b0;
    check("done_ov", d_out_valid, 0);
    check("done_rdy", d_in_ready, 1);
  endtask

  task automatic run_simple(input int which, input longint x);
    longint y, got;
    int l;
    l = (which == 0) ? 2 : 3;
    sh1[which] = sh0[which];
    sh0[which] = x;
    xin = 15'(x);
    if (which == 0) ovf_iv = 1'b1; else l3_iv = 1'b1;
    check("s_idle_rdy", (which == 0) ? ovf_rdy : l3_rdy, 1);
    @(posedge clk); #1;
    ovf_iv = 1'b0;
    l3_iv  = 1'b0;
    @(posedge clk); #1;
    for (int p = 0; p < l; p++) begin
      if (which == 0) y = ref_y(4, 2, 64'h1FF1, 0, 15, sh0[0], sh1[0], p);
      else            y = ref_y(6, 3, 64'h121121, 0, 18, sh0[1], sh1[1], p);
      got = (which == 0) ? longint'(ovf_out) : longint'(l3_out);
      check("s_ov", (which == 0) ? ovf_ov : l3_ov, 1);
      check("s_out", got, y);
      check("s_emit_rdy", (which == 0) ? ovf_rdy : l3_rdy, 0);
      @(posedge clk); #1;
    end
    check("s_done_ov", (which == 0) ? ovf_ov : l3_ov, 0);
    check("s_done_rdy", (which == 0) ? ovf_rdy : l3_rdy, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) check("excl", d_in_ready & d_out_valid, 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_in_valid = 1'b0;
    d_out_ready = 1'b0;
    ovf_iv = 1'b0;
    l3_iv = 1'b0;
    xin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", d_out_valid, 0);
    check("rst_out", d_out, 0);
    rst = 1'b0;
    #1;
    check("rst_rdy", d_in_ready, 1);
    @(posedge clk); #1;

    run_txn(100, 0);
    run_txn(40, 0);
    run_txn(100, -5);

    // asynchronous reset while y_0 is being presented
    xin = 15'sd100;
    d_in_valid = 1'b1;
    h1 = h0;
    h0 = 100;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out", d_out, ref_y(4, 2, 64'h1FF1, 1, 18, h0, h1, 0));
    rst = 1'b1;
    #1;
    check("mid_rst_ov", d_out_valid, 0);
    check("mid_rst_out", d_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    h0 = 0;
    h1 = 0;
    run_txn(100, 0);

    repeat (30) run_txn(longint'($urandom_range(32767)) - 16384, 3);

    run_simple(0, 16383);
    run_simple(0, -16384);
    run_simple(1, 10);
    run_simple(1, longint'($urandom_range(32767)) - 16384);
    run_simple(1, longint'($urandom_range(32767)) - 16384);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
